cache_arbiter: RTL and testbench

Two-requester arbiter that shares the single port of the unified SDRAM cache between instruction fetch (port 0) and load/store (port 1). It owns the cache's `enable`, `address`, `data_in` and `write_enable` inputs. It holds them stable for the whole cache transaction, including the cache's "busy + 1 cycle" hold requirement. It returns read data or a write acknowledge to the winning requester. It sits between the core's fetch/LSU and `cache`.

---
 rtl/cache_arbiter_if.sv | 41 ++++
 rtl/cache_arbiter.sv | 96 +++++++++
 tb/tb_cache_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Requester and cache-side signal bundle for cache_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the cache.
interface cache_arbiter_if;
  logic        p0_req;
  logic        p1_req;
  logic [31:0] p0_address;
  logic [31:0] p1_address;
  logic [31:0] p0_data_in;
  logic [31:0] p1_data_in;
  logic [3:0]  p0_write_enable;
  logic [3:0]  p1_write_enable;
  logic [31:0] p0_data_out;
  logic [31:0] p1_data_out;
  logic        p0_done;
  logic        p1_done;
  logic        p0_granted;
  logic        p1_granted;
  logic        cache_enable;
  logic [31:0] cache_address;
  logic [31:0] cache_data_in;
  logic [3:0]  cache_write_enable;
  logic [31:0] cache_data_out;
  logic        cache_data_out_ready;
  logic        cache_busy;

  modport slave (
    input  p0_req, p1_req, p0_address, p1_address, p0_data_in, p1_data_in,
           p0_write_enable, p1_write_enable,
           cache_data_out, cache_data_out_ready, cache_busy,
    output p0_data_out, p1_data_out, p0_done, p1_done, p0_granted, p1_granted,
           cache_enable, cache_address, cache_data_in, cache_write_enable
  );

  modport master (
    output p0_req, p1_req, p0_address, p1_address, p0_data_in, p1_data_in,
           p0_write_enable, p1_write_enable,
           cache_data_out, cache_data_out_ready, cache_busy,
    input  p0_data_out, p1_data_out, p0_done, p1_done, p0_granted, p1_granted,
           cache_enable, cache_address, cache_data_in, cache_write_enable
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-port arbiter sharing the unified cache between instruction fetch (port 0)
// and load/store (port 1); the owner's fields drive the cache until completion.
module cache_arbiter #(
  parameter int unsigned RoundRobin = 1
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  assign complete = (state_q != IDLE) && !bus.cache_busy;

  // Leaving an OWN state hands over directly to a pending other port, so no idle bubble.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (bus.p0_req && bus.p1_req) begin
          if (RoundRobin != 0) state_d = prio_q ? OWN1 : OWN0;
          else                 state_d = OWN1;
        end else if (bus.p0_req) begin
          state_d = OWN0;
        end else if (bus.p1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (complete) begin
          state_d = bus.p1_req ? OWN1 : IDLE;
          if (RoundRobin != 0) prio_d = 1'b1;
        end
      end
      OWN1: begin
        if (complete) begin
          state_d = bus.p0_req ? OWN0 : IDLE;
          if (RoundRobin != 0) prio_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cache_enable       = 1'b0;
    bus.cache_address      = '0;
    bus.cache_data_in      = '0;
    bus.cache_write_enable = '0;
    bus.p0_done            = 1'b0;
    bus.p1_done            = 1'b0;
    bus.p0_data_out        = '0;
    bus.p1_data_out        = '0;
    bus.p0_granted         = (state_q == OWN0);
    bus.p1_granted         = (state_q == OWN1);
    unique case (state_q)
      OWN0: begin
        bus.cache_enable       = 1'b1;
        bus.cache_address      = bus.p0_address;
        bus.cache_data_in      = bus.p0_data_in;
        bus.cache_write_enable = bus.p0_write_enable;
        bus.p0_done            = !bus.cache_busy;
        bus.p0_data_out        = bus.cache_data_out;
      end
      OWN1: begin
        bus.cache_enable       = 1'b1;
        bus.cache_address      = bus.p1_address;
        bus.cache_data_in      = bus.p1_data_in;
        bus.cache_write_enable = bus.p1_write_enable;
        bus.p1_done            = !bus.cache_busy;
        bus.p1_data_out        = bus.cache_data_out;
      end
      default: ;
    endcase
  end

  // A read completion without ready data means the cache broke its handshake.
  a_read_ready: assert property (@(posedge clk) disable iff (rst)
    (complete && bus.cache_write_enable == '0) |-> bus.cache_data_out_ready);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: one round-robin and one fixed-priority instance
// share a small behavioural cache model selected by sel.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr, p0_wd, p1_wd;
  logic [3:0]  p0_we, p1_we;
  logic        sel;
  int unsigned miss_lat;
  int unsigned busy_left = 0;
  logic [31:0] mem [0:4095];

  int unsigned checks = 0;
  int unsigned errors = 0;

  cache_arbiter_if b0();
  cache_arbiter_if b1();

  cache_arbiter #(.RoundRobin(1)) u_rr  (.clk(clk), .rst(rst), .bus(b0));
  cache_arbiter #(.RoundRobin(0)) u_fix (.clk(clk), .rst(rst), .bus(b1));

  logic        c_en, c_busy, c_ready;
  logic [31:0] c_addr, c_din, c_dout;
  logic [3:0]  c_we;
  logic        o_p0_done, o_p1_done, o_p0_g, o_p1_g;
  logic [31:0] o_p0_do, o_p1_do;

  assign c_en     = sel ? b1.cache_enable       : b0.cache_enable;
  assign c_addr   = sel ? b1.cache_address      : b0.cache_address;
  assign c_din    = sel ? b1.cache_data_in      : b0.cache_data_in;
  assign c_we     = sel ? b1.cache_write_enable : b0.cache_write_enable;
  assign o_p0_done = sel ? b1.p0_done     : b0.p0_done;
  assign o_p1_done = sel ? b1.p1_done     : b0.p1_done;
  assign o_p0_g    = sel ? b1.p0_granted  : b0.p0_granted;
  assign o_p1_g    = sel ? b1.p1_granted  : b0.p1_granted;
  assign o_p0_do   = sel ? b1.p0_data_out : b0.p0_data_out;
  assign o_p1_do   = sel ? b1.p1_data_out : b0.p1_data_out;

  assign c_busy  = c_en && (busy_left != 0);
  assign c_ready = c_en && !c_busy;
  assign c_dout  = mem[c_addr[13:2]];

  assign b0.p0_req = p0_req;   assign b1.p0_req = p0_req;
  assign b0.p1_req = p1_req;   assign b1.p1_req = p1_req;
  assign b0.p0_address = p0_addr;  assign b1.p0_address = p0_addr;
  assign b0.p1_address = p1_addr;  assign b1.p1_address = p1_addr;
  assign b0.p0_data_in = p0_wd;    assign b1.p0_data_in = p0_wd;
  assign b0.p1_data_in = p1_wd;    assign b1.p1_data_in = p1_wd;
  assign b0.p0_write_enable = p0_we;  assign b1.p0_write_enable = p0_we;
  assign b0.p1_write_enable = p1_we;  assign b1.p1_write_enable = p1_we;
  assign b0.cache_data_out = c_dout;  assign b1.cache_data_out = c_dout;
  assign b0.cache_busy = c_busy;      assign b1.cache_busy = c_busy;
  assign b0.cache_data_out_ready = c_ready;
  assign b1.cache_data_out_ready = c_ready;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Cache model: busy for miss_lat cycles at the start of each transaction, write at completion.
  always @(posedge clk) begin
    if (rst || !c_en || !c_busy) busy_left <= miss_lat;
    else                         busy_left <= busy_left - 1;
    if (!rst && c_en && !c_busy && c_we != 4'b0)
      mem[c_addr[13:2]] <= merge(mem[c_addr[13:2]], c_din, c_we);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    p0_req = 1'b0; p1_req = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wd = '0; p1_wd = '0; p0_we = '0; p1_we = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, k, port, cnt0, cnt1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A50000 | i;
    mem[12'h040] = 32'hDEADBEEF;
    mem[12'h0C0] = 32'h11223344;
    sel = 1'b0;
    miss_lat = 0;
    do_reset();

    // reset state
    check("rst_p0_granted", {31'b0, o_p0_g}, 0);
    check("rst_p1_granted", {31'b0, o_p1_g}, 0);
    check("rst_cache_en", {31'b0, c_en}, 0);
    check("rst_cache_addr", c_addr, 0);
    check("rst_cache_we", {28'b0, c_we}, 0);
    check("rst_done", {30'b0, o_p0_done, o_p1_done}, 0);
    check("rst_p0_data_out", o_p0_do, 0);
    check("rst_p1_data_out", o_p1_do, 0);

    // read hit, port 0
    p0_req = 1'b1; p0_addr = 32'h100; p0_we = 4'b0;
    #1 check("hit_no_grant_c0", {31'b0, o_p0_g}, 0);
    cyc();
    check("hit_granted", {31'b0, o_p0_g}, 1);
    check("hit_done", {31'b0, o_p0_done}, 1);
    check("hit_data", o_p0_do, 32'hDEADBEEF);
    check("hit_ready", {31'b0, c_ready}, 1);
    check("hit_addr", c_addr, 32'h100);
    p0_req = 1'b0;
    cyc();
    check("hit_idle_after", {30'b0, o_p0_g, c_en}, 0);
    check("hit_done_pulse", {31'b0, o_p0_done}, 0);

    // write miss, port 1, three busy cycles
    miss_lat = 3;
    p1_req = 1'b1; p1_addr = 32'h2000; p1_wd = 32'h12345678; p1_we = 4'hF;
    cyc();
    check("wm_granted", {31'b0, o_p1_g}, 1);
    n = 0;
    while (!o_p1_done && n < 20) begin
      check("wm_addr_stable", c_addr, 32'h2000);
      check("wm_we_stable", {28'b0, c_we}, 32'hF);
      n++;
      cyc();
    end
    check("wm_done", {31'b0, o_p1_done}, 1);
    check("wm_busy_cycles", n, 3);
    check("wm_addr_completion", c_addr, 32'h2000);
    check("wm_data_in", c_din, 32'h12345678);
    p1_req = 1'b0;
    cyc();
    miss_lat = 0;
    p0_req = 1'b1; p0_addr = 32'h2000; p0_we = 4'b0;
    cyc();
    check("wm_readback_done", {31'b0, o_p0_done}, 1);
    check("wm_readback", o_p0_do, 32'h12345678);
    p0_req = 1'b0;
    cyc();

    // simultaneous requests, round robin, 4 transactions each
    do_reset();
    miss_lat = 1;
    p0_req = 1'b1; p0_addr = 32'h100;  p0_we = 4'b0;
    p1_req = 1'b1; p1_addr = 32'h2000; p1_we = 4'b0;
    k = 0; cnt0 = 0; cnt1 = 0;
    for (int t = 1; t <= 40 && k < 8; t++) begin
      cyc();
      check("rr_owned", {31'b0, o_p0_g | o_p1_g}, 1);
      if (o_p0_done || o_p1_done) begin
        port = o_p1_done ? 1 : 0;
        check("rr_order", port, k % 2);
        check("rr_cycle", t, 2 * k + 2);
        if (port == 0) begin
          check("rr_p0_data", o_p0_do, 32'hDEADBEEF);
          cnt0++;
          if (cnt0 == 4) p0_req = 1'b0;
        end else begin
          check("rr_p1_data", o_p1_do, 32'h12345678);
          cnt1++;
          if (cnt1 == 4) p1_req = 1'b0;
        end
        k++;
      end
    end
    check("rr_p0_count", cnt0, 4);
    check("rr_p1_count", cnt1, 4);
    cyc();
    check("rr_idle_end", {30'b0, o_p0_g, o_p1_g}, 0);

    // fixed priority instance
    sel = 1'b1;
    do_reset();
    miss_lat = 0;
    p0_req = 1'b1; p0_addr = 32'h100;  p0_we = 4'b0;
    p1_req = 1'b1; p1_addr = 32'h2000; p1_we = 4'b0;
    #1 check("fp_c0_idle", {30'b0, o_p0_g, o_p1_g}, 0);
    cyc();
    check("fp_c1_owner", {30'b0, o_p0_g, o_p1_g}, 32'b01);
    check("fp_c1_done", {31'b0, o_p1_done}, 1);
    p1_req = 1'b0;
    cyc();
    check("fp_c2_owner", {30'b0, o_p0_g, o_p1_g}, 32'b10);
    check("fp_c2_data", o_p0_do, 32'hDEADBEEF);
    p1_req = 1'b1;
    cyc();
    check("fp_c3_owner", {30'b0, o_p0_g, o_p1_g}, 32'b01);
    p1_req = 1'b0;
    cyc();
    check("fp_c4_owner", {30'b0, o_p0_g, o_p1_g}, 32'b10);
    check("fp_c4_done", {31'b0, o_p0_done}, 1);
    p0_req = 1'b0;
    cyc();
    check("fp_c5_idle", {30'b0, o_p0_g, o_p1_g}, 0);
    p0_req = 1'b1; p1_req = 1'b1;
    cyc();
    check("fp_c6_tie", {30'b0, o_p0_g, o_p1_g}, 32'b01);
    p0_req = 1'b0; p1_req = 1'b0;
    cyc();
    check("fp_c7_idle", {30'b0, o_p0_g, o_p1_g}, 0);
    p0_req = 1'b1; p1_req = 1'b1;
    cyc();
    check("fp_c8_tie_after_p1", {30'b0, o_p0_g, o_p1_g}, 32'b01);
    p0_req = 1'b0; p1_req = 1'b0;
    cyc();
    sel = 1'b0;

    // partial write then readback
    do_reset();
    miss_lat = 0;
    p1_req = 1'b1; p1_addr = 32'h300; p1_wd = 32'hAABBCCDD; p1_we = 4'b0101;
    cyc();
    check("pw_done", {31'b0, o_p1_done}, 1);
    check("pw_cache_we", {28'b0, c_we}, 32'h5);
    check("pw_cache_din", c_din, 32'hAABBCCDD);
    p1_req = 1'b0;
    cyc();
    p0_req = 1'b1; p0_addr = 32'h300; p0_we = 4'b0;
    cyc();
    check("pw_readback", o_p0_do, 32'h11BB33DD);
    p0_req = 1'b0;
    cyc();

    // reset during a port 0 miss
    miss_lat = 4;
    p0_req = 1'b1; p0_addr = 32'h2000; p0_we = 4'b0;
    cyc();
    check("rm_granted", {31'b0, o_p0_g}, 1);
    check("rm_busy", {31'b0, c_busy}, 1);
    cyc();
    check("rm_no_done_busy", {31'b0, o_p0_done}, 0);
    rst = 1'b1;
    miss_lat = 1;
    #1 check("rm_no_done_rst", {31'b0, o_p0_done}, 0);
    cyc();
    check("rm_cleared_grant", {30'b0, o_p0_g, o_p1_g}, 0);
    check("rm_cleared_en", {31'b0, c_en}, 0);
    check("rm_cleared_addr", c_addr, 0);
    check("rm_cleared_done", {31'b0, o_p0_done}, 0);
    check("rm_cleared_data", o_p0_do, 0);
    rst = 1'b0;
    n = 0;
    while (!o_p0_done && n < 10) begin
      n++;
      cyc();
    end
    check("rm_rerequest_done", {31'b0, o_p0_done}, 1);
    check("rm_rerequest_data", o_p0_do, 32'h12345678);
    p0_req = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
